// File: rtl/rr_arbiter_16_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
package rr_arbiter_16_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;
  localparam logic [N_REQ-1:0] GNT_NONE = 16'hFFFF;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
    lowest_set = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (v[i-1]) lowest_set = IDX_W'(i - 1);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_16_grant_decoder.sv
// 4-to-16 decoder with active-low outputs; disabled drives all outputs high.
module grant_decoder
  import rr_arbiter_16_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] sel_n
);

  always_comb begin
    sel_n = GNT_NONE;
    if (en) sel_n[idx] = 1'b0;
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with hold-until-release grants.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt_n,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_16: MAX_HOLD must be within 2..255");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] win_idx;
  logic             owner_rel;
  logic             go_idle;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  // Rotate so ptr sits at bit 0, pick the lowest set bit, then rotate back.
  always_comb begin
    req_rot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_rot[i] = req[IDX_W'(i) + ptr_q];
    end
    win_idx = lowest_set(req_rot) + ptr_q;
  end

  assign owner_rel = done || !req[idx_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    go_idle = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          idx_d   = win_idx;
          valid_d = 1'b1;
          state_d = ARB_GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (owner_rel) go_idle = 1'b1;
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          go_idle   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
        if (go_idle) begin
          valid_d = 1'b0;
          ptr_d   = idx_q + 4'd1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  grant_decoder u_dec (
    .en    (valid_q),
    .idx   (idx_q),
    .sel_n (gnt_n)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed vectors plus randomized traffic vs a reference model.
module tb_rr_arbiter_16;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TB_MAX_HOLD = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int unsigned TB_MAX_HOLD = 64;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = 16'hFFFF;
  logic        done = 1'b0;
  logic [15:0] gnt_n;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: current owner (-1 = none), priority pointer, last index, hold count.
  int m_owner = -1;
  int m_ptr = 0;
  int m_idx = 0;
  int m_hold = 0;
  bit m_to = 1'b0;

  typedef struct {
    bit          rst_n;
    logic [15:0] req;
    bit          done;
    logic [15:0] e_gnt_n;
    bit          e_valid;
    logic [3:0]  e_idx;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  rr_arbiter_16 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  function automatic void add(input bit r, input logic [15:0] q, input bit d,
                              input logic [15:0] en, input bit ev, input logic [3:0] ei);
    vec_t v;
    v.rst_n = r; v.req = q; v.done = d;
    v.e_gnt_n = en; v.e_valid = ev; v.e_idx = ei;
    vecs.push_back(v);
  endfunction

  function automatic void model_edge(input bit r, input logic [15:0] q, input bit d);
    if (!r) begin
      m_owner = -1; m_ptr = 0; m_idx = 0; m_hold = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (d || !q[m_owner]) begin
        m_ptr = (m_owner + 1) % 16;
        m_owner = -1;
      end else if (TO_EN && m_hold == int'(TB_MAX_HOLD) - 1) begin
        m_ptr = (m_owner + 1) % 16;
        m_owner = -1;
        m_to = 1'b1;
      end else begin
        m_hold++;
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (q[(m_ptr + k) % 16]) begin
          m_owner = (m_ptr + k) % 16;
          m_idx = m_owner;
          m_hold = 0;
          break;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [15:0] en, input logic ev,
                       input logic [3:0] ei, input logic et);
    n_checks++;
    if (gnt_n !== en || gnt_valid !== ev || gnt_idx !== ei || timeout !== et) begin
      n_fail++;
      $display("FAIL %s @%0t: got gnt_n=%h valid=%b idx=%0d timeout=%b, expected gnt_n=%h valid=%b idx=%0d timeout=%b",
               name, $time, gnt_n, gnt_valid, gnt_idx, timeout, en, ev, ei, et);
    end
  endtask

  task automatic step(input bit r, input logic [15:0] q, input bit d);
    rst_n = r; req = q; done = d;
    @(posedge clk);
    model_edge(r, q, d);
    #1;
  endtask

  task automatic check_model(input string name);
    logic [15:0] oh;
    logic [3:0]  ei;
    oh = 16'h0001 << m_owner;
    ei = m_idx[3:0];
    check(name, (m_owner >= 0) ? ~oh : 16'hFFFF, m_owner >= 0, ei, m_to);
  endtask

  initial begin
    logic [15:0] oh;
    logic [15:0] rq;
    bit          hold_mode;

`ifndef ARB_TIMEOUT_EN
    add(0, 16'hFFFF, 0, 16'hFFFF, 0, 4'd0);
    add(0, 16'hFFFF, 0, 16'hFFFF, 0, 4'd0);
    add(1, 16'h0020, 0, 16'hFFDF, 1, 4'd5);
    for (int i = 0; i < 10; i++) add(1, 16'h0020, 0, 16'hFFDF, 1, 4'd5);
    add(1, 16'hFFFF, 0, 16'hFFDF, 1, 4'd5);
    add(1, 16'hFFDF, 0, 16'hFFFF, 0, 4'd5);
    add(1, 16'h0020, 0, 16'hFFDF, 1, 4'd5);
    add(1, 16'hFFFF, 1, 16'hFFFF, 0, 4'd5);
    add(1, 16'hFFFF, 0, 16'hFFBF, 1, 4'd6);
    add(1, 16'hFFFF, 1, 16'hFFFF, 0, 4'd6);
    add(1, 16'hFFFF, 0, 16'hFF7F, 1, 4'd7);
    add(1, 16'hFFFF, 0, 16'hFF7F, 1, 4'd7);
    add(0, 16'hFFFF, 0, 16'hFFFF, 0, 4'd0);
    add(1, 16'h0081, 0, 16'hFFFE, 1, 4'd0);
    add(1, 16'h0081, 1, 16'hFFFF, 0, 4'd0);
    add(1, 16'h0081, 0, 16'hFF7F, 1, 4'd7);
    add(1, 16'h0081, 1, 16'hFFFF, 0, 4'd7);
    add(1, 16'h0081, 0, 16'hFFFE, 1, 4'd0);
    add(1, 16'h0000, 1, 16'hFFFF, 0, 4'd0);
    add(1, 16'h0000, 1, 16'hFFFF, 0, 4'd0);
    add(1, 16'h0002, 0, 16'hFFFD, 1, 4'd1);
    add(1, 16'h0002, 0, 16'hFFFD, 1, 4'd1);
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].done);
      check($sformatf("vec[%0d]", i), vecs[i].e_gnt_n, vecs[i].e_valid, vecs[i].e_idx, 1'b0);
    end
`endif

    // Fairness: all requesting, one grant cycle each, one idle cycle between
    step(0, 16'hFFFF, 0);
    check("fair_reset", 16'hFFFF, 0, 4'd0, 0);
    for (int i = 0; i <= 16; i++) begin
      oh = 16'h0001 << (i % 16);
      step(1, 16'hFFFF, 0);
      check($sformatf("fair_grant[%0d]", i), ~oh, 1, 4'(i % 16), 0);
      step(1, 16'hFFFF, 1);
      check($sformatf("fair_idle[%0d]", i), 16'hFFFF, 0, 4'(i % 16), 0);
    end

    // Wrap and skip after owner 14
    step(0, 16'h0000, 0);
    step(1, 16'h4000, 0);
    check("wrap_own14", 16'hBFFF, 1, 4'd14, 0);
    step(1, 16'h0009, 1);
    check("wrap_rel14", 16'hFFFF, 0, 4'd14, 0);
    step(1, 16'h0009, 0);
    check("wrap_gnt0", 16'hFFFE, 1, 4'd0, 0);
    step(1, 16'h0009, 1);
    check("wrap_rel0", 16'hFFFF, 0, 4'd0, 0);
    step(1, 16'h0009, 0);
    check("wrap_gnt3", 16'hFFF7, 1, 4'd3, 0);

`ifdef ARB_TIMEOUT_EN
    for (int v = 0; v < 2; v++) begin
      step(0, 16'h0000, 0);
      check("to_reset", 16'hFFFF, 0, 4'd0, 0);
      for (int c = 0; c < 4; c++) begin
        step(1, 16'h0004, 0);
        check($sformatf("to_hold[%0d]", c), 16'hFFFB, 1, 4'd2, 0);
      end
      step(1, 16'h0004, 0);
      check("to_force", 16'hFFFF, 0, 4'd2, 1);
      if (v == 0) begin
        step(1, 16'h000C, 0);
        check("to_next3", 16'hFFF7, 1, 4'd3, 0);
      end else begin
        step(1, 16'h0004, 0);
        check("to_next2", 16'hFFFB, 1, 4'd2, 0);
      end
    end
    // Normal release on the limit edge wins over the forced one
    step(0, 16'h0000, 0);
    for (int c = 0; c < 4; c++) step(1, 16'h0004, 0);
    step(1, 16'h0004, 1);
    check("to_done_prio", 16'hFFFF, 0, 4'd2, 0);
`endif

    // Randomized traffic against the reference model
    step(0, 16'h0000, 0);
    check_model("rand_reset");
    hold_mode = 1'b0;
    rq = 16'h0000;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) hold_mode = ($urandom_range(0, 1) == 1);
      if (!hold_mode || n % 50 == 0) begin
        rq = 16'($urandom);
        if ($urandom_range(0, 2) == 0) rq &= 16'($urandom);
        if ($urandom_range(0, 9) == 0) rq = 16'h0000;
      end
      step($urandom_range(0, 199) != 0, rq,
           hold_mode ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 3) == 0));
      check_model($sformatf("rand[%0d]", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
